modexp_stream_io: RTL and testbench

MODEXP_STREAM_IO -- requirements
Module: modexp_stream_io

---
 rtl/modexp_stream_io.sv | 183 ++++++++++++++++++
 tb/tb_modexp_stream_io.sv | 301 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/modexp_stream_io.sv
// Streaming bridge for a modexp core: 27 operand words in, 9 result words out.
// Optional operand range check is enabled with `define MODEXP_RANGE_CHECK_EN.
module modexp_stream_io (
    input  logic         clk,
    input  logic         reset,
    input  logic [31:0]  in_data,
    input  logic         in_valid,
    output logic         in_ready,
    output logic [31:0]  out_data,
    output logic         out_valid,
    input  logic         out_ready,
    output logic         out_last,
    output logic [259:0] core_a,
    output logic [259:0] core_b,
    output logic [259:0] core_m,
    output logic         core_start,
    input  logic [259:0] core_result,
    input  logic         core_done,
    output logic         busy,
    output logic         error,
    output logic [2:0]   dbg_state
);

    // Both streams: a word moves on a rising edge where valid && ready; the
    // source holds data stable until then.
    typedef enum logic [2:0] {
        LOAD      = 3'd0,
        CHECK     = 3'd1,
        START     = 3'd2,
        WAIT_ACK  = 3'd3,
        WAIT_DONE = 3'd4,
        DRAIN     = 3'd5
    } state_t;

    state_t         state;
    logic [4:0]     word_cnt;
    logic [3:0]     k;
    logic [259:0]   op_a, op_b, op_m, result;
    logic [1:0]     op_sel;
    logic [3:0]     word_sel;

    function automatic logic [259:0] put_word(input logic [259:0] cur,
                                              input logic [3:0]   sel,
                                              input logic [31:0]  d);
        logic [259:0] r;
        r = cur;
        if (sel == 4'd8) r[259:256] = d[3:0];
        else             r[32*sel[2:0] +: 32] = d;
        return r;
    endfunction

    always_comb begin
        op_sel   = 2'd0;
        word_sel = word_cnt[3:0];
        if (word_cnt >= 5'd18) begin
            op_sel   = 2'd2;
            word_sel = 4'(word_cnt - 5'd18);
        end else if (word_cnt >= 5'd9) begin
            op_sel   = 2'd1;
            word_sel = 4'(word_cnt - 5'd9);
        end
    end

`ifdef MODEXP_RANGE_CHECK_EN
    logic [2:0] hi_flag;
    logic       error_q;
    logic       reject;
    assign reject = (|hi_flag) || (op_m <= 260'd1);
    assign error  = error_q;
`else
    assign error  = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= LOAD;
            word_cnt  <= 5'd0;
            k         <= 4'd0;
            op_a      <= '0;
            op_b      <= '0;
            op_m      <= '0;
            result    <= '0;
            in_ready  <= 1'b0;
            busy      <= 1'b0;
            out_valid <= 1'b0;
            out_last  <= 1'b0;
`ifdef MODEXP_RANGE_CHECK_EN
            hi_flag   <= 3'b000;
            error_q   <= 1'b0;
`endif
        end else begin
`ifdef MODEXP_RANGE_CHECK_EN
            error_q <= 1'b0;
`endif
            case (state)
                LOAD: begin
                    in_ready <= 1'b1;
                    busy     <= 1'b0;
                    if (in_valid && in_ready) begin
                        case (op_sel)
                            2'd0:    op_a <= put_word(op_a, word_sel, in_data);
                            2'd1:    op_b <= put_word(op_b, word_sel, in_data);
                            default: op_m <= put_word(op_m, word_sel, in_data);
                        endcase
`ifdef MODEXP_RANGE_CHECK_EN
                        if (word_sel == 4'd8 && (|in_data[31:4]))
                            hi_flag[op_sel] <= 1'b1;
`endif
                        if (word_cnt == 5'd26) begin
                            word_cnt <= 5'd0;
                            state    <= CHECK;
                            in_ready <= 1'b0;
                            busy     <= 1'b1;
                        end else begin
                            word_cnt <= word_cnt + 5'd1;
                        end
                    end
                end
                CHECK: begin
`ifdef MODEXP_RANGE_CHECK_EN
                    hi_flag <= 3'b000;
                    if (reject) begin
                        error_q  <= 1'b1;
                        state    <= LOAD;
                        in_ready <= 1'b1;
                        busy     <= 1'b0;
                    end else begin
                        state <= START;
                    end
`else
                    state <= START;
`endif
                end
                START: begin
                    if (core_done) state <= WAIT_ACK;
                end
                WAIT_ACK: begin
                    // The core acknowledges the start pulse by dropping done.
                    if (!core_done) state <= WAIT_DONE;
                end
                WAIT_DONE: begin
                    if (core_done) begin
                        result    <= core_result;
                        state     <= DRAIN;
                        out_valid <= 1'b1;
                        out_last  <= 1'b0;
                        k         <= 4'd0;
                    end
                end
                DRAIN: begin
                    if (out_ready) begin
                        if (k == 4'd8) begin
                            k         <= 4'd0;
                            state     <= LOAD;
                            out_valid <= 1'b0;
                            out_last  <= 1'b0;
                            in_ready  <= 1'b1;
                            busy      <= 1'b0;
                        end else begin
                            k        <= k + 4'd1;
                            out_last <= (k == 4'd7);
                        end
                    end
                end
                default: state <= LOAD;
            endcase
        end
    end

    // Start is gated by done combinationally so it can never fire at a busy core.
    assign core_start = (state == START) && core_done;

    always_comb begin
        if (k == 4'd8) out_data = {28'b0, result[259:256]};
        else           out_data = result[32*k[2:0] +: 32];
    end

    assign core_a    = op_a;
    assign core_b    = op_b;
    assign core_m    = op_m;
    assign dbg_state = state;

endmodule

// File: tb/tb_modexp_stream_io.sv
// Directed bench for modexp_stream_io: table of jobs plus reset, stall,
// done-hold, back-to-back and operand-rejection sequences.
module tb_modexp_stream_io;

    logic         clk;
    logic         reset;
    logic [31:0]  in_data;
    logic         in_valid;
    logic         in_ready;
    logic [31:0]  out_data;
    logic         out_valid;
    logic         out_ready;
    logic         out_last;
    logic [259:0] core_a, core_b, core_m;
    logic         core_start;
    logic [259:0] core_result;
    logic         core_done;
    logic         busy;
    logic         error;
    logic [2:0]   dbg_state;

    modexp_stream_io dut (
        .clk(clk), .reset(reset),
        .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
        .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready), .out_last(out_last),
        .core_a(core_a), .core_b(core_b), .core_m(core_m),
        .core_start(core_start), .core_result(core_result), .core_done(core_done),
        .busy(busy), .error(error), .dbg_state(dbg_state)
    );

    // ---------------- clock / watchdog ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- core model ----------------
    logic         core_idle_done;
    logic         hold_done;
    logic [259:0] model_res;
    logic [259:0] cap_a, cap_b, cap_m;
    int           start_count;

    assign core_done = core_idle_done && !hold_done;

    initial begin
        core_idle_done = 1'b1;
        core_result    = '0;
        start_count    = 0;
        cap_a = '0; cap_b = '0; cap_m = '0;
        forever begin
            @(negedge clk);
            if (core_start) begin
                start_count++;
                cap_a = core_a; cap_b = core_b; cap_m = core_m;
                @(posedge clk); #1;
                core_idle_done = 1'b0;
                repeat (3) @(posedge clk);
                #1;
                core_result    = model_res;
                core_idle_done = 1'b1;
            end
        end
    end

    // ---------------- scoreboard ----------------
    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string name, input logic [259:0] act, input logic [259:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic timeout_fail(input string name);
        n_tests++;
        n_fail++;
        $display("FAIL %s: timed out waiting for handshake", name);
    endtask

    function automatic logic [31:0] exp_word(input logic [259:0] r, input int idx);
        if (idx == 8) return {28'b0, r[259:256]};
        return r[32*idx +: 32];
    endfunction

    typedef struct {
        logic [259:0] a, b, m, res;
        logic [27:0]  up;
        logic [3:0]   pat;
    } vec_t;

    // ---------------- drivers ----------------
    task automatic send_words(input vec_t v, input int first, input int n);
        logic [259:0] op;
        int w, tmo;
        for (int i = first; i < n; i++) begin
            op = (i < 9) ? v.a : (i < 18) ? v.b : v.m;
            w  = i % 9;
            in_data  = (w == 8) ? {v.up, op[259:256]} : op[32*w +: 32];
            in_valid = 1'b1;
            tmo = 0;
            @(negedge clk);
            while (!in_ready && tmo < 200) begin
                @(negedge clk);
                tmo++;
            end
            if (!in_ready) begin
                timeout_fail("in_handshake");
                in_valid = 1'b0;
                return;
            end
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        in_data  = '0;
    endtask

    // Collects 9 words under a cyclic ready pattern; ends at posedge+1.
    task automatic recv(input vec_t v, input bit pre, input logic [31:0] pre_word);
        int idx, cyc;
        logic stalled;
        logic [31:0] held;
        idx = 0; cyc = 0; stalled = 1'b0; held = '0;
        while (idx < 9 && cyc < 300) begin
            @(negedge clk);
            out_ready = v.pat[cyc % 4];
            cyc++;
            if (out_valid) begin
                if (stalled) check("stall_hold", {228'b0, out_data}, {228'b0, held});
                if (out_ready) begin
                    check("out_word", {228'b0, out_data}, {228'b0, exp_word(v.res, idx)});
                    check("out_last", {259'b0, out_last}, {259'b0, (idx == 8)});
                    check("core_m_stable", core_m, v.m);
                    stalled = 1'b0;
                    idx++;
                    if (idx == 9 && pre) begin
                        in_valid = 1'b1;
                        in_data  = pre_word;
                    end
                end else begin
                    stalled = 1'b1;
                    held    = out_data;
                end
            end
        end
        if (idx < 9) timeout_fail("out_handshake");
        @(posedge clk); #1;
        out_ready = 1'b0;
        @(negedge clk);
        check("ready_after_drain", {259'b0, in_ready}, 260'd1);
        check("valid_after_drain", {259'b0, out_valid}, 260'd0);
        check("busy_after_drain", {259'b0, busy}, 260'd0);
        @(posedge clk); #1;
    endtask

    task automatic run_job(input vec_t v, input int first, input bit pre, input logic [31:0] pre_word);
        int sc0;
        model_res = v.res;
        sc0 = start_count;
        send_words(v, first, 27);
        @(negedge clk);
        check("busy_in_check", {259'b0, busy}, 260'd1);
        check("no_start_in_check", {259'b0, core_start}, 260'd0);
        @(negedge clk);
        check("start_latency", {259'b0, core_start}, 260'd1);
        recv(v, pre, pre_word);
        check("start_once", 260'(start_count - sc0), 260'd1);
        check("core_a", cap_a, v.a);
        check("core_b", cap_b, v.b);
        check("core_m", cap_m, v.m);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        @(posedge clk); #1;
    endtask

    // ---------------- test ----------------
    vec_t vec [4];
    vec_t e_m1, e_hi;

    initial begin
        // Core results are what the core model hands back: a^b mod m.
        vec[0] = '{a: 260'd2, b: 260'd10, m: 260'd1000, res: 260'd24, up: 28'h0, pat: 4'b1111};
        vec[1] = '{a: 260'd3, b: 260'd4,  m: 260'd7,    res: 260'd4,  up: 28'h0, pat: 4'b1001};
        vec[2] = '{a: 260'd5, b: 260'd3,  m: 260'd13,   res: 260'd8,  up: 28'h0, pat: 4'b1001};
        vec[3] = '{a: {4'hC, 32'h11111111, 32'h22222222, 32'h33333333, 32'h44444444,
                        32'h55555555, 32'h66666666, 32'h77777777, 32'h88888888},
                   b: 260'd65537,
                   m: {4'hF, {8{32'hffffffff}}},
                   res: {4'h9, 32'h87654321, 32'h0fedcba9, 32'h13579bdf, 32'h2468ace0,
                          32'hdeadbeef, 32'hcafef00d, 32'h01234567, 32'h89abcdef},
                   up: 28'h0, pat: 4'b1010};
        e_m1 = '{a: 260'd2, b: 260'd3, m: 260'd1,   res: 260'd0,  up: 28'h0, pat: 4'b1111};
        e_hi = '{a: 260'd7, b: 260'd2, m: 260'd100, res: 260'd49, up: 28'h1, pat: 4'b1111};

        in_data = '0; in_valid = 1'b0; out_ready = 1'b0;
        hold_done = 1'b0; model_res = '0;

        // Reset state
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("rst_in_ready", {259'b0, in_ready}, 260'd0);
        check("rst_busy", {259'b0, busy}, 260'd0);
        check("rst_out_valid", {259'b0, out_valid}, 260'd0);
        check("rst_out_last", {259'b0, out_last}, 260'd0);
        check("rst_error", {259'b0, error}, 260'd0);
        check("rst_core_start", {259'b0, core_start}, 260'd0);
        check("rst_core_a", core_a, 260'd0);
        check("rst_core_m", core_m, 260'd0);
        reset = 1'b0;
        @(posedge clk); #1;
        check("post_rst_in_ready", {259'b0, in_ready}, 260'd1);
        check("post_rst_busy", {259'b0, busy}, 260'd0);

        // Table of jobs; job 1 ends with the next job's first word already valid
        begin
            bit carry;
            carry = 1'b0;
            for (int i = 0; i < 4; i++) begin
                bit pre;
                logic [31:0] pw;
                pre = (i == 1);
                pw  = (i < 3) ? exp_word(vec[i+1].a, 0) : 32'h0;
                run_job(vec[i], carry ? 1 : 0, pre, pw);
                carry = pre;
            end
        end

        // Core reports busy after reset: start must be withheld until done rises
        hold_done = 1'b1;
        do_reset();
        repeat (5) @(posedge clk);
        #1;
        begin
            int sc0;
            sc0 = start_count;
            model_res = vec[0].res;
            send_words(vec[0], 0, 27);
            repeat (3) @(negedge clk);
            check("start_withheld", {259'b0, core_start}, 260'd0);
            check("held_in_start", {257'b0, dbg_state}, 260'd2);
            check("no_start_count", 260'(start_count - sc0), 260'd0);
            @(posedge clk); #1;
            hold_done = 1'b0;
            @(negedge clk);
            check("start_after_release", {259'b0, core_start}, 260'd1);
            recv(vec[0], 1'b0, 32'h0);
            check("hold_start_once", 260'(start_count - sc0), 260'd1);
        end

        // Reset after 13 words; only the following job may reach the core
        send_words(vec[1], 0, 13);
        do_reset();
        run_job(vec[2], 0, 1'b0, 32'h0);

        // Word-8 upper bits and m==1
`ifdef MODEXP_RANGE_CHECK_EN
        for (int j = 0; j < 2; j++) begin
            vec_t e;
            int sc0;
            e = (j == 0) ? e_m1 : e_hi;
            sc0 = start_count;
            send_words(e, 0, 27);
            @(negedge clk);
            check("err_not_yet", {259'b0, error}, 260'd0);
            @(negedge clk);
            check("err_pulse", {259'b0, error}, 260'd1);
            check("err_in_ready", {259'b0, in_ready}, 260'd1);
            @(negedge clk);
            check("err_one_cycle", {259'b0, error}, 260'd0);
            check("err_no_start", 260'(start_count - sc0), 260'd0);
            @(posedge clk); #1;
        end
        run_job(vec[1], 0, 1'b0, 32'h0);
`else
        run_job(e_m1, 0, 1'b0, 32'h0);
        check("err_tied_low", {259'b0, error}, 260'd0);
        begin
            vec_t e;
            e = e_hi;
            run_job(e, 0, 1'b0, 32'h0);
            check("err_tied_low_hi", {259'b0, error}, 260'd0);
        end
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
